// File: rtl/hwtimer_mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hwtimer_mc_pkg                                                           |
// | Shared constants and helpers for the multi-channel hardware timer:       |
// | register offsets, CTRL bit positions, channel stride, bus lane helpers.  |
// | Revision: 1.0 - initial multi-channel release                            |
// +--------------------------------------------------------------------------+
package hwtimer_mc_pkg;

  localparam int CH_STRIDE = 32;

  // Byte offsets of the per-channel registers inside one channel window
  localparam logic [4:0] OFS_CTRL  = 5'h00;
  localparam logic [4:0] OFS_LOAD  = 5'h04;
  localparam logic [4:0] OFS_CNT   = 5'h08;
  localparam logic [4:0] OFS_PRESC = 5'h0C;
  localparam logic [4:0] OFS_CMP   = 5'h10;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_UPD     = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQEN   = 3;
  localparam int CTRL_PEND    = 4;
  localparam int CTRL_HIT     = 5;

  // Decoded per-channel write strobes
  typedef struct packed {
    logic ctrl;
    logic load;
    logic presc;
    logic cmp;
  } wr_strb_t;

  // Byte enables: 2**size bytes starting at the lane given by addr[1:0]
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << lane;
  endfunction

  // Replace only the enabled bytes of old_val with those of new_val
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwtimer_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hwtimer_ch                                                               |
// | One timer channel: prescaler, down-counter (periodic/oneshot), sticky    |
// | W1C pending bit and optional compare (pwm) output.                       |
// | Optional feature macro: HWTIMER_MC_PWM_EN (CMP register + pwm output).   |
// | Ports: clk/rst_n (async active-low); we_* decoded write strobes;         |
// |   wdata lane-shifted write data; be byte enables; *_rd register          |
// |   readback; hit (cnt==0), pending, irq_en, pwm.                          |
// | Revision: 1.0 - initial multi-channel release                            |
// +--------------------------------------------------------------------------+
module hwtimer_ch
  import hwtimer_mc_pkg::*;
#(
  parameter int CW = 32,
  parameter int PW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_ctrl,
  input  logic        we_load,
  input  logic        we_presc,
  input  logic        we_cmp,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] cnt_rd,
  output logic [31:0] presc_rd,
  output logic [31:0] cmp_rd,
  output logic        hit,
  output logic        pending,
  output logic        irq_en,
  output logic        pwm
);

  logic          en;
  logic          upd;
  logic          oneshot;
  logic          pend;
  logic [CW-1:0] load;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic          expire;
  logic          ctrl_we;

  // All CTRL fields live in byte 0
  assign ctrl_we = we_ctrl & be[0];
  assign tick    = en & (pcnt == presc);
  assign hit     = (cnt == '0);
  assign pending = pend;

  // Counter step on a tick; a pending update swallows the tick
  always_comb begin
    cnt_nxt = cnt;
    expire  = 1'b0;
    if (tick && !upd) begin
      if (cnt > CW'(1)) begin
        cnt_nxt = cnt - CW'(1);
      end else if (cnt == CW'(1)) begin
        cnt_nxt = '0;
        expire  = 1'b1;
      end else if (!oneshot) begin
        cnt_nxt = load;
        expire  = (load == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      upd     <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
      pend    <= 1'b0;
      load    <= '0;
      cnt     <= '0;
      presc   <= '0;
      pcnt    <= '0;
    end else begin
      // update is a one-cycle pulse acted on in the following cycle
      upd <= ctrl_we & wdata[CTRL_UPD];

      if (upd) begin
        cnt  <= load;
        pcnt <= '0;
      end else begin
        cnt  <= cnt_nxt;
        pcnt <= (en && !tick) ? pcnt + PW'(1) : '0;
      end

      // A bus write to CTRL overrides the oneshot auto-disable
      if (ctrl_we) begin
        en      <= wdata[CTRL_EN];
        oneshot <= wdata[CTRL_ONESHOT];
        irq_en  <= wdata[CTRL_IRQEN];
      end else if (expire && oneshot) begin
        en <= 1'b0;
      end

      // Set wins over a simultaneous write-1-to-clear
      if (expire) begin
        pend <= 1'b1;
      end else if (ctrl_we && wdata[CTRL_PEND]) begin
        pend <= 1'b0;
      end

      if (we_load)  load  <= CW'(merge_bytes(32'(load),  wdata, be));
      if (we_presc) presc <= PW'(merge_bytes(32'(presc), wdata, be));
    end
  end

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_EN]      = en;
    ctrl_rd[CTRL_UPD]     = upd;
    ctrl_rd[CTRL_ONESHOT] = oneshot;
    ctrl_rd[CTRL_IRQEN]   = irq_en;
    ctrl_rd[CTRL_PEND]    = pend;
    ctrl_rd[CTRL_HIT]     = hit;
  end

  assign load_rd  = 32'(load);
  assign cnt_rd   = 32'(cnt);
  assign presc_rd = 32'(presc);

`ifdef HWTIMER_MC_PWM_EN
  logic [CW-1:0] cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= '0;
      pwm <= 1'b0;
    end else begin
      if (we_cmp) cmp <= CW'(merge_bytes(32'(cmp), wdata, be));
      pwm <= en & (cnt < cmp);
    end
  end

  assign cmp_rd = 32'(cmp);
`else
  logic unused_we_cmp;
  assign unused_we_cmp = we_cmp;
  assign pwm           = 1'b0;
  assign cmp_rd        = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/hwtimer_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hwtimer_mc                                                               |
// | NCH-channel hardware timer on the c_* valid/ready register bus.          |
// | Optional feature macro: HWTIMER_MC_PWM_EN (per-channel CMP + pwm).       |
// | Ports: c_clk, c_rstb (async active-low); irq (registered OR of           |
// |   pending&irq_enable); hit[NCH] (cnt==0); pwm[NCH]; bus c_valid,         |
// |   c_write, c_addr, c_size, c_wdata -> c_ready, c_rdata (1-cycle).        |
// | Map: channel = addr[8:5] (32 B stride), register = addr[4:2].            |
// | Revision: 1.0 - initial multi-channel release                            |
// +--------------------------------------------------------------------------+
module hwtimer_mc
  import hwtimer_mc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PW  = 16
) (
  input  logic           c_clk,
  input  logic           c_rstb,
  output logic           irq,
  output logic [NCH-1:0] hit,
  output logic [NCH-1:0] pwm,
  output logic           c_ready,
  output logic [31:0]    c_rdata,
  input  logic [31:0]    c_wdata,
  input  logic           c_write,
  input  logic [31:0]    c_addr,
  input  logic [1:0]     c_size,
  input  logic           c_valid
);

  localparam int CH_LSB = $clog2(CH_STRIDE);

  logic [3:0]            ch;
  logic [4:0]            ofs;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           wdata_sh;
  logic                  bus_wr;
  logic [31:0]           rd_word;
  logic [NCH-1:0][31:0]  ctrl_rd_a;
  logic [NCH-1:0][31:0]  load_rd_a;
  logic [NCH-1:0][31:0]  cnt_rd_a;
  logic [NCH-1:0][31:0]  presc_rd_a;
  logic [NCH-1:0][31:0]  cmp_rd_a;
  logic [NCH-1:0]        pend_a;
  logic [NCH-1:0]        irqen_a;
  logic                  unused_addr;

  assign ch          = c_addr[CH_LSB +: 4];
  assign ofs         = {c_addr[CH_LSB-1:2], 2'b00};
  assign lane        = c_addr[1:0];
  assign be          = lane_mask(c_size, lane);
  assign wdata_sh    = c_wdata << {lane, 3'b000};
  assign bus_wr      = c_valid & c_write;
  assign unused_addr = ^c_addr[31:CH_LSB+4];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    wr_strb_t strb;
    logic     sel;

    assign sel        = bus_wr & (ch == 4'(i));
    assign strb.ctrl  = sel & (ofs == OFS_CTRL);
    assign strb.load  = sel & (ofs == OFS_LOAD);
    assign strb.presc = sel & (ofs == OFS_PRESC);
    assign strb.cmp   = sel & (ofs == OFS_CMP);

    hwtimer_ch #(
      .CW (CW),
      .PW (PW)
    ) u_ch (
      .clk      (c_clk),
      .rst_n    (c_rstb),
      .we_ctrl  (strb.ctrl),
      .we_load  (strb.load),
      .we_presc (strb.presc),
      .we_cmp   (strb.cmp),
      .wdata    (wdata_sh),
      .be       (be),
      .ctrl_rd  (ctrl_rd_a[i]),
      .load_rd  (load_rd_a[i]),
      .cnt_rd   (cnt_rd_a[i]),
      .presc_rd (presc_rd_a[i]),
      .cmp_rd   (cmp_rd_a[i]),
      .hit      (hit[i]),
      .pending  (pend_a[i]),
      .irq_en   (irqen_a[i]),
      .pwm      (pwm[i])
    );
  end

  // Channels >= NCH never match, so they read as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 4'(i)) begin
        case (ofs)
          OFS_CTRL:  rd_word = ctrl_rd_a[i];
          OFS_LOAD:  rd_word = load_rd_a[i];
          OFS_CNT:   rd_word = cnt_rd_a[i];
          OFS_PRESC: rd_word = presc_rd_a[i];
          OFS_CMP:   rd_word = cmp_rd_a[i];
          default:   rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      c_ready <= 1'b0;
      c_rdata <= '0;
      irq     <= 1'b0;
    end else begin
      c_ready <= c_valid;
      c_rdata <= (c_valid && !c_write) ? (rd_word >> {lane, 3'b000}) : '0;
      irq     <= |(pend_a & irqen_a);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwtimer_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hwtimer_mc                                                            |
// | Scoreboard bench for hwtimer_mc: bus requests push expected read data,   |
// | a monitor pops on c_ready; hit/irq/pwm are compared every cycle against  |
// | a behavioural reference model of the timer rules.                        |
// | Revision: 1.0 - initial                                                  |
// +--------------------------------------------------------------------------+
module tb_hwtimer_mc;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;
  localparam bit [31:0] CMASK = 32'((64'd1 << CW) - 64'd1);
  localparam bit [31:0] PMASK = 32'((64'd1 << PW) - 64'd1);

  logic           clk;
  logic           rstb;
  logic           irq;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] pwm;
  logic           c_ready;
  logic [31:0]    c_rdata;
  logic [31:0]    c_wdata;
  logic           c_write;
  logic [31:0]    c_addr;
  logic [1:0]     c_size;
  logic           c_valid;

  hwtimer_mc #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .c_clk   (clk),
    .c_rstb  (rstb),
    .irq     (irq),
    .hit     (hit),
    .pwm     (pwm),
    .c_ready (c_ready),
    .c_rdata (c_rdata),
    .c_wdata (c_wdata),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_size  (c_size),
    .c_valid (c_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        is_rd;
    bit [31:0] addr;
    bit [31:0] exp;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  // Reference model state
  bit [31:0] m_load [NCH];
  bit [31:0] m_cnt  [NCH];
  bit [31:0] m_presc[NCH];
  bit [31:0] m_pcnt [NCH];
  bit [31:0] m_cmp  [NCH];
  bit        m_en   [NCH];
  bit        m_upd  [NCH];
  bit        m_os   [NCH];
  bit        m_ie   [NCH];
  bit        m_pend [NCH];
  bit        m_pwm  [NCH];
  bit        m_irq;

  bit pwm_meas;
  int pwm_hi;

  task automatic chk(input string name, input logic [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] A(input int ch, input int ofs);
    return 32'(ch * 32 + ofs);
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] a);
    int ch = int'(a[8:5]);
    int ofs = int'(a[4:2]);
    bit [31:0] r = 0;
    if (ch < NCH) begin
      case (ofs)
        0: r = {26'd0, m_cnt[ch] == 0, m_pend[ch], m_ie[ch], m_os[ch], m_upd[ch], m_en[ch]};
        1: r = m_load[ch];
        2: r = m_cnt[ch];
        3: r = m_presc[ch];
`ifdef HWTIMER_MC_PWM_EN
        4: r = m_cmp[ch];
`endif
        default: r = 0;
      endcase
    end
    return r >> (8 * a[1:0]);
  endfunction

  function automatic bit [31:0] mmerge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    bit [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // True when the next clock edge makes channel c expire
  function automatic bit will_expire(input int c);
    if (!(m_en[c] && m_pcnt[c] == m_presc[c]) || m_upd[c]) return 0;
    return (m_cnt[c] == 1) || (m_cnt[c] == 0 && !m_os[c] && m_load[c] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_load[i] = 0; m_cnt[i] = 0; m_presc[i] = 0; m_pcnt[i] = 0; m_cmp[i] = 0;
      m_en[i] = 0; m_upd[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_pwm[i] = 0;
    end
    m_irq = 0;
  endtask

  // One clock of the timer rules, given the bus inputs seen on that edge
  task automatic model_step(input bit v, input bit w, input bit [31:0] a,
                            input bit [1:0] sz, input bit [31:0] wd);
    int ch, ofs, nb;
    bit [3:0] be;
    bit [31:0] wsh, cnt_n, pcnt_n;
    bit irq_n, tick, exp, wr_here, ctrl_w;
    ch  = int'(a[8:5]);
    ofs = int'(a[4:2]);
    nb  = 1 << sz;
    if (nb > 4) nb = 4;
    be  = 4'((((1 << nb) - 1) << a[1:0]) & 15);
    wsh = wd << (8 * a[1:0]);
    irq_n = 0;
    for (int i = 0; i < NCH; i++) irq_n |= m_pend[i] & m_ie[i];
    for (int i = 0; i < NCH; i++) begin
      wr_here = v && w && (ch == i);
      ctrl_w  = wr_here && ofs == 0 && be[0];
      tick    = m_en[i] && (m_pcnt[i] == m_presc[i]);
      exp     = 0;
      cnt_n   = m_cnt[i];
      pcnt_n  = (m_en[i] && !tick) ? ((m_pcnt[i] + 1) & PMASK) : 0;
      if (m_upd[i]) begin
        cnt_n = m_load[i];
        pcnt_n = 0;
      end else if (tick) begin
        if (m_cnt[i] > 1) cnt_n = m_cnt[i] - 1;
        else if (m_cnt[i] == 1) begin cnt_n = 0; exp = 1; end
        else if (!m_os[i]) begin cnt_n = m_load[i]; exp = (m_load[i] == 0); end
      end
`ifdef HWTIMER_MC_PWM_EN
      m_pwm[i] = m_en[i] && (m_cnt[i] < m_cmp[i]);
`else
      m_pwm[i] = 0;
`endif
      if (exp && m_os[i]) m_en[i] = 0;
      m_upd[i] = 0;
      if (ctrl_w) begin
        m_en[i]  = wsh[0];
        m_upd[i] = wsh[1];
        m_os[i]  = wsh[2];
        m_ie[i]  = wsh[3];
        if (wsh[4]) m_pend[i] = 0;
      end
      if (exp) m_pend[i] = 1;
      if (wr_here && ofs == 1) m_load[i]  = mmerge(m_load[i],  wsh, be) & CMASK;
      if (wr_here && ofs == 3) m_presc[i] = mmerge(m_presc[i], wsh, be) & PMASK;
`ifdef HWTIMER_MC_PWM_EN
      if (wr_here && ofs == 4) m_cmp[i]   = mmerge(m_cmp[i],   wsh, be) & CMASK;
`endif
      m_cnt[i]  = cnt_n;
      m_pcnt[i] = pcnt_n;
    end
    m_irq = irq_n;
  endtask

  task automatic check_outputs();
    bit [NCH-1:0] eh, ep;
    for (int i = 0; i < NCH; i++) begin
      eh[i] = (m_cnt[i] == 0);
      ep[i] = m_pwm[i];
    end
    chk("hit", 32'(hit), 32'(eh));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("pwm", 32'(pwm), 32'(ep));
    if (pwm_meas && pwm[3]) pwm_hi++;
  endtask

  task automatic cycle(input bit v, input bit w, input bit [31:0] a,
                       input bit [1:0] sz, input bit [31:0] wd);
    sb_t e;
    @(negedge clk);
    check_outputs();
    c_valid = v; c_write = w; c_addr = a; c_size = sz; c_wdata = wd;
    @(posedge clk);
    if (v) begin
      e.is_rd = !w;
      e.addr  = a;
      e.exp   = model_read(a);
      sb.push_back(e);
    end
    model_step(v, w, a, sz, wd);
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d);
    cycle(1, 1, a, 2'd2, d);
  endtask

  task automatic rd(input bit [31:0] a);
    cycle(1, 0, a, 2'd2, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 2'd0, 0);
  endtask

  // Scoreboard monitor: every request gets c_ready on the next cycle
  always @(negedge clk) begin
    if (rstb) begin
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("bus_ready", 32'(c_ready), 1);
        if (mon_e.is_rd) chk($sformatf("rdata@%08h", mon_e.addr), c_rdata, mon_e.exp);
      end else if (c_ready) begin
        chk("spurious_ready", 32'(c_ready), 0);
      end
    end
  end

  initial begin
    int guard;
    bit [31:0] a, d;
    int rch, rofs, rlane;
    bit [1:0] rsz;
    bit rw;

    rstb = 0; c_valid = 0; c_write = 0; c_addr = 0; c_size = 0; c_wdata = 0;
    pwm_meas = 0; pwm_hi = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstb = 1;
    #1;
    chk("rst_irq",   32'(irq),     0);
    chk("rst_ready", 32'(c_ready), 0);
    chk("rst_rdata", c_rdata,      0);
    chk("rst_pwm",   32'(pwm),     0);
    chk("rst_hit",   32'(hit),     32'({NCH{1'b1}}));

    // Periodic channel 0: LOAD=3, PRESC=0, enable+update+irq_enable
    wr(A(0, 4), 3);
    wr(A(0, 12), 0);
    wr(A(0, 0), 32'h0B);
    for (int k = 0; k < 8; k++) rd(A(0, 8));
    rd(A(0, 0));
    idle(6);

    // Prescaled channel 1: W1C on the expire cycle keeps pending set
    wr(A(1, 4), 2);
    wr(A(1, 12), 4);
    wr(A(1, 0), 32'h01);
    guard = 0;
    while (!m_pend[1] && guard < 200) begin idle(1); guard++; end
    chk("prescale_first_expire_in_time", 32'(guard < 200), 1);
    wr(A(1, 0), 32'h11);
    rd(A(1, 0));
    guard = 0;
    while (!will_expire(1) && guard < 200) begin idle(1); guard++; end
    chk("prescale_expire_found", 32'(guard < 200), 1);
    wr(A(1, 0), 32'h11);
    rd(A(1, 0));

    // Oneshot channel 2
    wr(A(2, 4), 5);
    wr(A(2, 0), 32'h07);
    idle(12);
    rd(A(2, 0));
    rd(A(2, 8));
    wr(A(2, 0), 32'h14);
    idle(10);
    rd(A(2, 0));

    // Byte / halfword lanes on channel 0 LOAD
    wr(A(0, 4), 3);
    cycle(1, 1, A(0, 4) + 1, 2'd0, 32'hAB);
    rd(A(0, 4));
    cycle(1, 0, A(0, 4) + 2, 2'd1, 0);
    cycle(1, 0, A(0, 4) + 1, 2'd0, 0);

    // Unmapped offsets and channels
    rd(A(0, 20));
    wr(A(5, 4), 32'h55);
    rd(A(5, 4));
    rd(A(15, 0));

    // Compare output on channel 3
    wr(A(3, 4), 9);
    wr(A(3, 16), 3);
    wr(A(3, 0), 32'h03);
    rd(A(3, 16));
    idle(12);
    pwm_meas = 1;
    idle(20);
    pwm_meas = 0;
`ifdef HWTIMER_MC_PWM_EN
    chk("pwm_high_cycles_of_20", 32'(pwm_hi), 6);
`else
    chk("pwm_high_cycles_of_20", 32'(pwm_hi), 0);
`endif

    // Asynchronous reset while channel 3 is mid-count
    guard = 0;
    while (m_cnt[3] != 7 && guard < 100) begin idle(1); guard++; end
    chk("cnt7_reached", 32'(guard < 100), 1);
    @(negedge clk);
    c_valid = 0; c_write = 0;
    #1 rstb = 0;
    #1;
    chk("async_rst_hit",   32'(hit),     32'({NCH{1'b1}}));
    chk("async_rst_irq",   32'(irq),     0);
    chk("async_rst_ready", 32'(c_ready), 0);
    chk("async_rst_pwm",   32'(pwm),     0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rstb = 1;
    rd(A(3, 8));
    rd(A(0, 0));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rch  = $urandom_range(0, NCH + 1);
      rofs = $urandom_range(0, 7);
      rsz  = 2'($urandom_range(0, 2));
      rw   = 1'($urandom_range(0, 1));
      case (rsz)
        2'd0:    rlane = $urandom_range(0, 3);
        2'd1:    rlane = 2 * $urandom_range(0, 1);
        default: rlane = 0;
      endcase
      a = A(rch, rofs * 4 + rlane);
      case (rofs)
        0:       d = $urandom & 32'h1F;
        1, 3, 4: d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      cycle(1, rw, a, rsz, d);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
